// File: rtl/ram_burst_reader.sv
// Burst read sequencer: issues consecutive RAM reads and streams the words out with m_last on the final beat.
// Optional stall counter output enabled by defining RAM_BURST_READER_STALL_CNT_EN.
module ram_burst_reader #(
    parameter int depth      = 16,
    parameter int data_width = 32,
    parameter int addr_width = 32
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_wea,
    output logic [addr_width-1:0] ram_addra,
    input  logic [data_width-1:0] ram_douta,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_last
`ifdef RAM_BURST_READER_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_next;
    logic [addr_width-1:0]   len_q;
    logic [addr_width-1:0]   issued;
    logic                    issue_v, issue_last;
    logic                    data_v, data_last;
    logic [data_width-1:0]   fifo_data [4];
    logic                    fifo_last [4];
    logic [1:0]              rd_ptr, wr_ptr;
    logic [2:0]              count;
    logic [2:0]              credit_used;
    logic                    accept, issue, pop, burst_end;

    function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a);
        next_addr = (a >= addr_width'(depth - 1)) ? '0 : a + addr_width'(1);
    endfunction

    // Stream: a beat transfers when m_valid && m_ready; m_valid/m_data/m_last hold until then.
    assign ram_wea = 1'b0;
    assign m_valid = (count != 3'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = m_valid & fifo_last[rd_ptr];

    // Reads still in the RAM pipeline count against the FIFO so a push never finds it full.
    assign credit_used = count + {2'b00, issue_v} + {2'b00, data_v};

    always_comb begin
        state_next = state;
        accept     = start && (state == IDLE) && !busy;
        pop        = m_valid && m_ready;
        burst_end  = (state == DRAIN) && pop && m_last;
        issue      = (state == RUN) && (issued < len_q) && (credit_used < 3'd4);
        case (state)
            IDLE: begin
                if (accept && (length != '0))
                    state_next = (length == addr_width'(1)) ? DRAIN : RUN;
            end
            RUN: begin
                if (issue && (issued + addr_width'(1) == len_q))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (burst_end)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_addra  <= '0;
            len_q      <= '0;
            issued     <= '0;
            issue_v    <= 1'b0;
            issue_last <= 1'b0;
            data_v     <= 1'b0;
            data_last  <= 1'b0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            state <= state_next;
            done  <= burst_end | (accept && (length == '0));
            busy  <= (state_next != IDLE) | burst_end;

            // The accept itself is the first issue, so the address is on the RAM one cycle later.
            if (accept && (length != '0)) begin
                ram_addra  <= base_addr;
                len_q      <= length;
                issued     <= addr_width'(1);
                issue_v    <= 1'b1;
                issue_last <= (length == addr_width'(1));
            end else if (issue) begin
                ram_addra  <= next_addr(ram_addra);
                issued     <= issued + addr_width'(1);
                issue_v    <= 1'b1;
                issue_last <= (issued + addr_width'(1) == len_q);
            end else begin
                issue_v    <= 1'b0;
                issue_last <= 1'b0;
            end

            data_v    <= issue_v;
            data_last <= issue_last;

            if (data_v) begin
                fifo_data[wr_ptr] <= ram_douta;
                fifo_last[wr_ptr] <= data_last;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, data_v} - {2'b00, pop};
        end
    end

`ifdef RAM_BURST_READER_STALL_CNT_EN
    always_ff @(posedge clka) begin
        if (!rsta_n)
            stall_cnt <= '0;
        else if (accept)
            stall_cnt <= '0;
        else if (m_valid && !m_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Burst read sequencer placed directly downstream of the accelerator's single-port write-first block RAMs (weights, activations, latent buffers). On a start command it issues a run of consecutive read addresses to one RAM, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream with a last-beat marker to the next compute stage. Backpressure is fully supported with no lost or duplicated words.

## Interface
- depth, 16: words in the attached RAM; addresses wrap from depth-1 to 0
- data_width, 32: RAM and stream word width
- addr_width, 32: RAM address width; also the width of base_addr and length
- clka  in  1  clock shared with the attached RAM
- rsta_n  in  1  reset; synchronous, active-low
- start  in  1  command strobe; accepted only in IDLE
- base_addr  in  addr_width  first address of burst, sampled on start accept
- length  in  addr_width  number of words, sampled on start accept; 0 legal
- busy  out  1  high from the cycle after start accept until the done cycle, inclusive
- done  out  1  one-cycle pulse at burst completion
- ram_wea  out  1  tied 0; the reader never writes
- ram_addra  out  addr_width  registered read address to RAM
- ram_douta  in  data_width  RAM read data, valid one cycle after ram_addra
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  data_width  stream word
- m_last  out  1  high with the final word of the burst

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: when start=1 and length≠0, latch base_addr and length, go to RUN. When start=1 and length=0, no RAM read occurs; done pulses the next cycle and the FSM stays in IDLE.
- RUN: issue one read per cycle while the issue count is below length and the sum of FIFO occupancy and in-flight reads is below 4. Each issue registers ram_addra and advances it by 1, wrapping at depth-1 to 0. After the last issue, go to DRAIN.
- DRAIN: wait until all issued words have left the stream. On the handshake of the word flagged m_last, return to IDLE with done pulsing in the following cycle.
- Output FIFO: 4 entries. A read issued in cycle k is written from ram_douta at the end of cycle k+1. m_data and m_valid come registered from the FIFO head.
- Stream handshake: a word transfers when m_valid and m_ready are both 1. While m_valid=1 and m_ready=0, m_data and m_last stay stable. m_valid never drops before the transfer.
- m_last is set on exactly the length-th word.
- start while busy=1: ignored, with no effect on the current burst.
- Credit rule: the sum of FIFO occupancy and in-flight reads never exceeds 4, so FIFO overflow is impossible.

## Timing
- Reset values: busy=0, done=0, ram_wea=0, ram_addra=0, m_valid=0, m_data=0, m_last=0. FSM is in IDLE, FIFO is empty, counters are 0.
- Start accepted in cycle 0:
  - ram_addra = base_addr in cycle 1
  - first m_valid in cycle 3
- With m_ready held at 1, words appear in consecutive cycles 3 … 3+length-1. done pulses in cycle 3+length.
- A read issue and a FIFO pop in the same cycle are both legal.
- A FIFO push and a pop in the same cycle keep occupancy unchanged.
- Reset asserted mid-burst: at that clock edge, in-flight reads are discarded, the FIFO is flushed, and all outputs return to reset values. done does not pulse.

## Configuration
- Macro: RAM_BURST_READER_STALL_CNT_EN.
- Defined: adds output port stall_cnt (32 bits).
  - Increments in every cycle with m_valid=1 and m_ready=0, saturating at 2^32-1.
  - Cleared to 0 on reset and on start accept.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic burst:
  - Stimulus: depth=16, RAM preloaded with word i = i, base=2, length=5, m_ready=1.
  - Response: m_data 2,3,4,5,6 in cycles 3–7, m_last in cycle 7, done in cycle 8.
- Wrap: base=14, length=4, depth=16 → m_data 14,15,0,1, in order.
- Backpressure:
  - Stimulus: length=8, m_ready toggles 1,0,0,1,… in a fixed pattern.
  - Response: all 8 words delivered in order with no duplicates, data stable during stalls, FIFO never overflows.
  - With the macro defined, stall_cnt equals the number of stalled cycles.
- length=0 → no ram_addra change and no m_valid; done pulses one cycle after start; busy stays 0.
- Start during burst: a second start while busy=1 with a different base has no effect; the burst completes unchanged.
- Reset mid-burst: rsta_n=0 in cycle 5 of a length=10 burst → all outputs return to reset values next cycle; no done pulse; a new burst afterwards behaves normally.
